// File: rtl/pcie_us_msix_gen_pkg.sv
// Shared definitions for the UltraScale MSI-X interrupt generator:
// FSM state encoding and the per-vector table dword offsets.
package pcie_us_msix_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } msix_state_t;

  // Each vector occupies four dwords in the table, selected by the low
  // two bits of the table write address.
  localparam logic [1:0] DW_ADDR_LO = 2'd0;
  localparam logic [1:0] DW_ADDR_HI = 2'd1;
  localparam logic [1:0] DW_DATA    = 2'd2;
  localparam logic [1:0] DW_VCTRL   = 2'd3;

endpackage

// File: rtl/pcie_us_msix_rr_arb.sv
// Round-robin priority encoder: picks the first requesting vector at or
// after last+1, wrapping modulo NUM_VECTORS (NUM_VECTORS is a power of two,
// so the wrap is plain VEC_W-bit overflow).
module pcie_us_msix_rr_arb
  import pcie_us_msix_gen_pkg::*;
#(
  parameter int NUM_VECTORS = 32,
  localparam int VEC_W = $clog2(NUM_VECTORS)
) (
  input  logic [NUM_VECTORS-1:0] req,
  input  logic [VEC_W-1:0]       last,
  output logic                   grant_valid,
  output logic [VEC_W-1:0]       grant_idx
);

  logic [VEC_W-1:0] cand;

  // Scan from the farthest offset down to last+1 so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_VECTORS; i >= 1; i--) begin
      cand = last + VEC_W'(i);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pcie_us_msix_gen.sv
// MSI-X interrupt generator for the UltraScale PCIe cfg_interrupt_msix_*
// interface. Holds the MSI-X table and PBA, arbitrates pending vectors
// round-robin, and runs one request/response handshake at a time.
// Optional build macro PCIE_MSIX_TIMEOUT_EN: abandons a handshake that sees
// no sent/fail within TIMEOUT_CYCLES cycles of WAIT, treating it as a fail.
module pcie_us_msix_gen
  import pcie_us_msix_gen_pkg::*;
#(
  parameter int NUM_VECTORS    = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int VEC_W = $clog2(NUM_VECTORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VEC_W-1:0]       irq_index,
  input  logic                   irq_valid,
  output logic                   irq_ready,
  input  logic                   tbl_wr_en,
  input  logic [VEC_W+1:0]       tbl_wr_addr,
  input  logic [31:0]            tbl_wr_data,
  input  logic [3:0]             cfg_interrupt_msix_enable,
  input  logic [3:0]             cfg_interrupt_msix_mask,
  output logic [63:0]            cfg_interrupt_msix_address,
  output logic [31:0]            cfg_interrupt_msix_data,
  output logic                   cfg_interrupt_msix_int,
  input  logic                   cfg_interrupt_msix_sent,
  input  logic                   cfg_interrupt_msix_fail,
  output logic [NUM_VECTORS-1:0] pending,
  output logic                   busy
);

  if (NUM_VECTORS < 2 || NUM_VECTORS > 256 ||
      (NUM_VECTORS & (NUM_VECTORS - 1)) != 0) begin : g_bad_num_vectors
    $error("NUM_VECTORS must be a power of two in 2..256");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  msix_state_t            state;
  logic [VEC_W-1:0]       cur_vec;
  logic [VEC_W-1:0]       last_vec;
  logic [NUM_VECTORS-1:0] pending_q;
  logic [NUM_VECTORS-1:0] vec_mask;
  logic [NUM_VECTORS-1:0] eligible;
  logic                   grant_valid;
  logic [VEC_W-1:0]       grant_idx;
  logic [VEC_W-1:0]       wr_vec;
  logic [1:0]             wr_dw;
  logic                   func_on;
  logic                   resp_done;
  logic                   clear_pend;
  logic                   cfg_unused_bits;

  // Address/data storage has no reset so it can map onto RAM.
  logic [31:0] addr_lo_mem [NUM_VECTORS];
  logic [31:0] addr_hi_mem [NUM_VECTORS];
  logic [31:0] data_mem    [NUM_VECTORS];

`ifdef PCIE_MSIX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign wr_vec = tbl_wr_addr[VEC_W+1:2];
  assign wr_dw  = tbl_wr_addr[1:0];

  // Only PF0 exists here; the other function bits are deliberately ignored.
  assign func_on         = cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0];
  assign cfg_unused_bits = ^{cfg_interrupt_msix_enable[3:1], cfg_interrupt_msix_mask[3:1]};

  assign eligible = pending_q & ~vec_mask & {NUM_VECTORS{func_on}};

  // A simultaneous sent and fail is treated as a fail, so the vector stays pending.
  assign resp_done  = cfg_interrupt_msix_sent | cfg_interrupt_msix_fail;
  assign clear_pend = (state == ST_WAIT) && cfg_interrupt_msix_sent && !cfg_interrupt_msix_fail;

  assign irq_ready = 1'b1;
  assign pending   = pending_q;
  assign busy      = (state != ST_IDLE);

  pcie_us_msix_rr_arb #(
    .NUM_VECTORS (NUM_VECTORS)
  ) u_arb (
    .req         (eligible),
    .last        (last_vec),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Table address/data dwords: plain synchronous writes, no reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      case (wr_dw)
        DW_ADDR_LO: addr_lo_mem[wr_vec] <= tbl_wr_data;
        DW_ADDR_HI: addr_hi_mem[wr_vec] <= tbl_wr_data;
        DW_DATA:    data_mem[wr_vec]    <= tbl_wr_data;
        default:    ;
      endcase
    end
  end

  // Per-vector mask bit from vector control; vectors come out of reset masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_mask <= '1;
    end else if (tbl_wr_en && wr_dw == DW_VCTRL) begin
      vec_mask[wr_vec] <= tbl_wr_data[0];
    end
  end

  // Pending bit array: a new request for a vector beats its own completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      if (clear_pend) begin
        pending_q[cur_vec] <= 1'b0;
      end
      if (irq_valid) begin
        pending_q[irq_index] <= 1'b1;
      end
    end
  end

  // Handshake FSM: pick a vector, read its entry, pulse int, wait for a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                      <= ST_IDLE;
      cur_vec                    <= '0;
      last_vec                   <= '1;
      cfg_interrupt_msix_int     <= 1'b0;
      cfg_interrupt_msix_address <= '0;
      cfg_interrupt_msix_data    <= '0;
`ifdef PCIE_MSIX_TIMEOUT_EN
      wait_cnt                   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_vec <= grant_idx;
            state   <= ST_RD;
          end
        end
        ST_RD: begin
          cfg_interrupt_msix_address <= {addr_hi_mem[cur_vec], addr_lo_mem[cur_vec]};
          cfg_interrupt_msix_data    <= data_mem[cur_vec];
          cfg_interrupt_msix_int     <= 1'b1;
          state                      <= ST_REQ;
        end
        ST_REQ: begin
          cfg_interrupt_msix_int <= 1'b0;
          state                  <= ST_WAIT;
`ifdef PCIE_MSIX_TIMEOUT_EN
          wait_cnt               <= '0;
`endif
        end
        ST_WAIT: begin
          if (resp_done) begin
            last_vec <= cur_vec;
            state    <= ST_IDLE;
          end
`ifdef PCIE_MSIX_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            last_vec <= cur_vec;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_us_msix_gen.sv
// Self-checking bench for pcie_us_msix_gen: scoreboard of expected MSI-X
// writes, table-driven eligibility records, and hand-written sequences for
// round-robin, retry, masking, set-wins, timeout and reset corner cases.
module tb_pcie_us_msix_gen;

  localparam int NV = 32;
  localparam int VW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] irq_index = '0;
  logic          irq_valid = 1'b0;
  logic          irq_ready;
  logic          tbl_wr_en = 1'b0;
  logic [VW+1:0] tbl_wr_addr = '0;
  logic [31:0]   tbl_wr_data = '0;
  logic [3:0]    msix_enable = '0;
  logic [3:0]    msix_mask = '0;
  logic [63:0]   msix_address;
  logic [31:0]   msix_data;
  logic          msix_int;
  logic          msix_sent = 1'b0;
  logic          msix_fail = 1'b0;
  logic [NV-1:0] pending;
  logic          busy;

  pcie_us_msix_gen #(
    .NUM_VECTORS    (NV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .irq_index                  (irq_index),
    .irq_valid                  (irq_valid),
    .irq_ready                  (irq_ready),
    .tbl_wr_en                  (tbl_wr_en),
    .tbl_wr_addr                (tbl_wr_addr),
    .tbl_wr_data                (tbl_wr_data),
    .cfg_interrupt_msix_enable  (msix_enable),
    .cfg_interrupt_msix_mask    (msix_mask),
    .cfg_interrupt_msix_address (msix_address),
    .cfg_interrupt_msix_data    (msix_data),
    .cfg_interrupt_msix_int     (msix_int),
    .cfg_interrupt_msix_sent    (msix_sent),
    .cfg_interrupt_msix_fail    (msix_fail),
    .pending                    (pending),
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int         vec;
    bit         vmask;
    logic [3:0] en;
    logic [3:0] fm;
    bit         exp_int;
  } vec_rec_t;

  exp_t     exp_q[$];
  vec_rec_t recs[8];
  int       tests_run = 0;
  int       tests_failed = 0;
  int       int_count = 0;
  bit       int_prev = 1'b0;

  // Reference table contents, independent of the DUT.
  function automatic logic [31:0] model_lo(input int v);
    return 32'hFEE0_0000 + 32'((v ^ 5) << 12);
  endfunction

  function automatic logic [31:0] model_data(input int v);
    return 32'h0000_4020 + 32'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to the next falling edge and score any int pulse seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (msix_int === 1'b1) begin
      int_count++;
      checkOutput("int_pulse_width", {63'd0, int_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_int: got addr 0x%0h data 0x%0h, expected no int", msix_address, msix_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("int_address", msix_address, e.addr);
        checkOutput("int_data", {32'd0, msix_data}, {32'd0, e.data});
      end
    end
    int_prev = (msix_int === 1'b1);
  endtask

  task automatic expect_vec(input int v);
    exp_t e;
    e.addr = {32'h0000_0001, model_lo(v)};
    e.data = model_data(v);
    exp_q.push_back(e);
  endtask

  task automatic wait_int(input int max_ticks, output int waited);
    int start;
    start  = int_count;
    waited = 0;
    while (int_count == start && waited < max_ticks) begin
      tick();
      waited++;
    end
    if (int_count == start) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL int_wait_timeout: got no int in %0d cycles, expected an int", max_ticks);
    end
  endtask

  task automatic pulse_irq(input int v);
    irq_index = VW'(v);
    irq_valid = 1'b1;
    tick();
    irq_valid = 1'b0;
  endtask

  task automatic respond(input bit s, input bit f);
    tick();
    msix_sent = s;
    msix_fail = f;
    tick();
    msix_sent = 1'b0;
    msix_fail = 1'b0;
  endtask

  task automatic write_dw(input int v, input int dw, input logic [31:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 7'(v * 4 + dw);
    tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_rec_t r);
    int start;
    int w;
    write_dw(r.vec, 3, {31'd0, r.vmask});
    msix_enable = r.en;
    msix_mask   = r.fm;
    if (r.exp_int) expect_vec(r.vec);
    start = int_count;
    pulse_irq(r.vec);
    repeat (4) tick();
    checkOutput($sformatf("rec%0d_int_count", idx), 64'(int_count - start), r.exp_int ? 64'd1 : 64'd0);
    if (r.exp_int) begin
      respond(1'b1, 1'b0);
    end else begin
      checkOutput($sformatf("rec%0d_held", idx), {63'd0, pending[r.vec]}, 64'd1);
      msix_enable = 4'b0001;
      msix_mask   = 4'b0000;
      expect_vec(r.vec);
      write_dw(r.vec, 3, 32'd0);
      wait_int(10, w);
      respond(1'b1, 1'b0);
    end
    checkOutput($sformatf("rec%0d_cleared", idx), {63'd0, pending[r.vec]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int n;

    recs[0] = '{vec: 3,  vmask: 1'b0, en: 4'b0001, fm: 4'b0000, exp_int: 1'b1};
    recs[1] = '{vec: 7,  vmask: 1'b1, en: 4'b0001, fm: 4'b0000, exp_int: 1'b0};
    recs[2] = '{vec: 10, vmask: 1'b0, en: 4'b0000, fm: 4'b0000, exp_int: 1'b0};
    recs[3] = '{vec: 12, vmask: 1'b0, en: 4'b0001, fm: 4'b0001, exp_int: 1'b0};
    recs[4] = '{vec: 31, vmask: 1'b0, en: 4'b0001, fm: 4'b0000, exp_int: 1'b1};
    recs[5] = '{vec: 0,  vmask: 1'b0, en: 4'b0001, fm: 4'b0000, exp_int: 1'b1};
    recs[6] = '{vec: 20, vmask: 1'b0, en: 4'b1110, fm: 4'b0000, exp_int: 1'b0};
    recs[7] = '{vec: 21, vmask: 1'b0, en: 4'b0001, fm: 4'b1110, exp_int: 1'b1};

    // Reset state
    repeat (3) tick();
    checkOutput("rst_int", {63'd0, msix_int}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_address", msix_address, 64'd0);
    checkOutput("rst_data", {32'd0, msix_data}, 64'd0);
    checkOutput("irq_ready", {63'd0, irq_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Vectors come out of reset masked: a request must stay pending.
    msix_enable = 4'b0001;
    pulse_irq(2);
    repeat (4) tick();
    checkOutput("rst_vmask_pending", {63'd0, pending[2]}, 64'd1);
    checkOutput("rst_vmask_idle", {63'd0, busy}, 64'd0);

    // Program the whole table with the function disabled.
    msix_enable = 4'b0000;
    for (int v = 0; v < NV; v++) begin
      write_dw(v, 0, model_lo(v));
      write_dw(v, 1, 32'h0000_0001);
      write_dw(v, 2, model_data(v));
      write_dw(v, 3, 32'd0);
    end
    checkOutput("disabled_idle", {63'd0, busy}, 64'd0);
    expect_vec(2);
    msix_enable = 4'b0001;
    wait_int(10, w);
    respond(1'b1, 1'b0);

    // Vector 5 basic issue with exact latency
    expect_vec(5);
    pulse_irq(5);
    checkOutput("v5_pending", {63'd0, pending[5]}, 64'd1);
    wait_int(10, w);
    checkOutput("v5_latency", 64'(w), 64'd2);
    respond(1'b1, 1'b0);
    checkOutput("v5_cleared", {63'd0, pending[5]}, 64'd0);
    checkOutput("v5_idle", {63'd0, busy}, 64'd0);

    // Eligibility table
    for (int i = 0; i < 8; i++) applyStimulus(i, recs[i]);

    // Round robin 1,2,3 then 1 re-pended lands after 2,3
    msix_mask = 4'b0001;
    pulse_irq(1);
    pulse_irq(2);
    pulse_irq(3);
    repeat (3) tick();
    checkOutput("rr_fmask_idle", {63'd0, busy}, 64'd0);
    expect_vec(1);
    expect_vec(2);
    expect_vec(3);
    expect_vec(1);
    msix_mask = 4'b0000;
    wait_int(10, w);
    respond(1'b1, 1'b0);
    pulse_irq(1);
    for (int k = 0; k < 3; k++) begin
      wait_int(10, w);
      respond(1'b1, 1'b0);
    end
    checkOutput("rr_all_clear", 64'(pending), 64'd0);

    // Vector mask holds vector 7 for 100 cycles, unmask issues in 2
    write_dw(7, 3, 32'd1);
    pulse_irq(7);
    n = int_count;
    repeat (100) tick();
    checkOutput("mask7_no_int", 64'(int_count - n), 64'd0);
    checkOutput("mask7_pending", {63'd0, pending[7]}, 64'd1);
    expect_vec(7);
    write_dw(7, 3, 32'd0);
    wait_int(10, w);
    checkOutput("mask7_latency", 64'(w), 64'd2);
    respond(1'b1, 1'b0);

    // Fail on 4 gives 9 priority; sent+fail counts as fail
    expect_vec(4);
    expect_vec(9);
    expect_vec(4);
    expect_vec(4);
    pulse_irq(4);
    pulse_irq(9);
    wait_int(10, w);
    respond(1'b0, 1'b1);
    checkOutput("fail4_kept", {63'd0, pending[4]}, 64'd1);
    wait_int(10, w);
    respond(1'b1, 1'b0);
    checkOutput("sent9_clear", {63'd0, pending[9]}, 64'd0);
    wait_int(10, w);
    respond(1'b1, 1'b1);
    checkOutput("sentfail4_kept", {63'd0, pending[4]}, 64'd1);
    wait_int(10, w);
    respond(1'b1, 1'b0);
    checkOutput("retry_all_clear", 64'(pending), 64'd0);

    // New request in the same cycle as sent for that vector keeps it pending
    expect_vec(6);
    pulse_irq(6);
    wait_int(10, w);
    tick();
    msix_sent = 1'b1;
    irq_index = VW'(6);
    irq_valid = 1'b1;
    tick();
    msix_sent = 1'b0;
    irq_valid = 1'b0;
    checkOutput("setwins_pending", {63'd0, pending[6]}, 64'd1);
    expect_vec(6);
    wait_int(10, w);
    respond(1'b1, 1'b0);
    checkOutput("setwins_clear", {63'd0, pending[6]}, 64'd0);

    // Disabling the function mid-handshake does not abort it
    expect_vec(8);
    pulse_irq(8);
    wait_int(10, w);
    msix_enable = 4'b0000;
    msix_mask   = 4'b0001;
    respond(1'b1, 1'b0);
    checkOutput("noabort_clear", {63'd0, pending[8]}, 64'd0);
    checkOutput("noabort_idle", {63'd0, busy}, 64'd0);
    msix_enable = 4'b0001;
    msix_mask   = 4'b0000;

`ifdef PCIE_MSIX_TIMEOUT_EN
    // No response: back to IDLE after TO cycles of WAIT, vector kept
    expect_vec(11);
    pulse_irq(11);
    wait_int(10, w);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 40);
    checkOutput("timeout_cycles", 64'(n), 64'(TO + 1));
    checkOutput("timeout_kept", {63'd0, pending[11]}, 64'd1);
    expect_vec(11);
    wait_int(10, w);
`else
    expect_vec(13);
    pulse_irq(13);
    wait_int(10, w);
`endif

    // Asynchronous reset while int is high drops the request at once
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_int", {63'd0, msix_int}, 64'd0);
    checkOutput("arst_pending", 64'(pending), 64'd0);
    checkOutput("arst_busy", {63'd0, busy}, 64'd0);
    checkOutput("arst_address", msix_address, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("post_rst_idle", {63'd0, busy}, 64'd0);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
